uart_mmio_fifo: RTL and testbench
=================================

# uart_mmio_fifo

Memory-mapped I/O block between the CPU data-memory port and the `UART` module. It replaces direct one-byte UART handshaking with parametrised TX and RX FIFOs, fill-level status and drop counting. It also provides the cycle and instruction counters. It sits beside the data cache on the same address/strobe bus and is selected by the upper address nibble `4'h8`.

## Interface
Parameters:
- `TX_DEPTH`, 8: TX FIFO entries. Must be a power of two, ≥2.
- `RX_DEPTH`, 8: RX FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, 32: width of the cycle and instruction counters (≤32).

Ports:
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst`  in  1: reset. **Synchronous, active-high.**
- `stall`  in  1: memory-system stall. While high, CPU accesses have no effect.
- `addr`  in  32: CPU data address. The block is selected when `addr[31:28]==4'h8`.
- `we`  in  4: byte write strobes. Any nonzero value is a write.
- `re`  in  1: read enable.
- `din`  in  32: write data. TX data is taken from `din[7:0]`.
- `dout`  out  32: registered read data.
- `instr_retire`  in  1: one instruction retired this cycle.
- `DataIn`  out  8: byte to UART transmitter.
- `DataInValid`  out  1: TX FIFO not empty.
- `DataInReady`  in  1: UART transmitter accepts a byte.
- `DataOut`  in  8: byte from UART receiver.
- `DataOutValid`  in  1: UART receiver holds a byte.
- `DataOutReady`  out  1: RX FIFO not full.

## Operation
Register map (offset = `addr[7:0]`, word-aligned):
- `0x00` TX status (read-only):
  - bit0 = TX not full
  - bits[15:8] = TX fill count
  - bits[23:16] = TX drop count
- `0x04` RX status (read-only):
  - bit0 = RX not empty
  - bits[15:8] = RX fill count
- `0x08` TX data (write-only): push `din[7:0]`.
- `0x0C` RX data (read-only): pop, returns `{24'b0, byte}`. Returns 0 with no pop if the RX FIFO is empty.
- `0x10` cycle counter (read-only).
- `0x14` instruction counter (read-only).
- `0x18` counter reset (write-only): any write clears both counters and the TX drop count.
- Unmapped offsets read 0 and ignore writes.

CPU access rules:
- An access is effective only when it is selected and `stall==0`.
- Write and read in the same cycle: the write takes effect and `dout` updates from the read.

TX FIFO:
- Pushed by an effective write to `0x08`.
- Popped when `DataInValid && DataInReady`.
- Push while full is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and the drop count increments, saturating at 255.

RX FIFO:
- Pushed when `DataOutValid && DataOutReady`.
- Popped by an effective read of `0x0C`.
- Backpressure only: bytes are never dropped. While `DataOutReady` is 0, the UART holds its byte.
- Push and pop in the same cycle while full: the pop frees the entry, but `DataOutReady` was already 0, so there is no push that cycle.

Counters:
- The cycle counter increments every cycle.
- The instruction counter increments when `instr_retire && !stall`.
- Both wrap modulo 2^`CNT_W`.
- A counter-reset write in the same cycle as an increment wins: the counter becomes 0.

Fill counts:
- Widths are `$clog2(DEPTH)+1`, zero-extended into bits[15:8].
- A full FIFO reports exactly `DEPTH`.
- Read and write pointers wrap at `DEPTH` with no special-case logic.

## Timing
- `dout` is registered: data for the access in cycle N appears in cycle N+1.
- While `stall` is high, `dout` holds its value.
- Status reads reflect state before the same-cycle edge.
- `DataIn` and `DataInValid` are combinational from the TX FIFO head.
- `DataOutReady` is combinational from the RX full flag.
- A pushed TX byte is visible on `DataIn` the cycle after the push.
- Reset values:
  - `dout`=0
  - both FIFOs empty, so `DataInValid`=0 and `DataOutReady`=1 one cycle after reset
  - counters=0, drop count=0
- Reset mid-transfer discards all FIFO contents. The UART's own state is reset by the same `rst`.

## Structure
- Shared package `mmio_pkg`:
  - offset constants `MMIO_TX_STAT`, `MMIO_RX_STAT`, `MMIO_TX_DATA`, `MMIO_RX_DATA`, `MMIO_CYC`, `MMIO_INSTR`, `MMIO_CNT_RST`
  - select nibble `MMIO_SEL=4'h8`
- One sub-module, `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`
  - ports: push, pop, din, dout, full, empty, count
  - instantiated twice
- Decode, counters and the `dout` register stay in `uart_mmio_fifo`.

## Test plan
- **Reset, then read `0x00` and `0x04`** -> `dout`=`32'h0000_0001` and `32'h0000_0000`. `DataOutReady`=1, `DataInValid`=0.
- **TX overflow**: `DataInReady`=0, write 10 bytes `0x41..0x4A` to `0x08` with depth 8. Expected:
  - TX status = `32'h0002_0800`
  - on releasing `DataInReady`, bytes `0x41..0x48` appear in order
- **RX backpressure**: UART presents 9 bytes while the CPU does not read. Expected: `DataOutReady` falls after 8 pushes. Reading `0x0C` returns the first byte, `DataOutReady` rises, and the 9th byte is then accepted.
- **Stall**: read `0x0C` with `stall`=1 for 3 cycles -> no pop, `dout` unchanged. The first cycle with `stall`=0 pops exactly one byte.
- **Counters**: pulse `instr_retire` 5 times over 20 cycles, one of them with `stall`=1 -> instruction counter = 4. Write `0x18` -> both counters read 0 on the next read, and the drop count clears.
- **Empty RX read** returns 0. **Simultaneous full-TX push and pop** is accepted with no drop increment.

Source files
------------

// File: rtl/uart_mmio_fifo_pkg.sv
// mmio_pkg: register offsets and select nibble for the UART MMIO block.
package mmio_pkg;
    localparam logic [3:0] MMIO_SEL     = 4'h8;
    localparam logic [7:0] MMIO_TX_STAT = 8'h00;
    localparam logic [7:0] MMIO_RX_STAT = 8'h04;
    localparam logic [7:0] MMIO_TX_DATA = 8'h08;
    localparam logic [7:0] MMIO_RX_DATA = 8'h0C;
    localparam logic [7:0] MMIO_CYC     = 8'h10;
    localparam logic [7:0] MMIO_INSTR   = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST = 8'h18;
endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; a push while full succeeds only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wp - rp;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: CPU MMIO window onto UART TX/RX FIFOs plus cycle and instruction counters.
module uart_mmio_fifo
    import mmio_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        instr_retire,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    logic sel, wr, rd, cnt_rst;
    logic [7:0] off;
    logic tx_push, tx_pop, tx_full, tx_empty;
    logic rx_push, rx_pop, rx_full, rx_empty;
    logic [TX_CW-1:0] tx_count;
    logic [RX_CW-1:0] rx_count;
    logic [7:0] rx_byte, drop;
    logic [CNT_W-1:0] cyc, instr;
    logic [31:0] rdata;
    logic unused_bits;
    assign unused_bits = ^{addr[27:8], din[31:8]};
    assign sel     = addr[31:28] == MMIO_SEL && !stall;
    assign off     = addr[7:0];
    assign wr      = sel && |we;
    assign rd      = sel && re;
    assign cnt_rst = wr && off == MMIO_CNT_RST;
    assign tx_push = wr && off == MMIO_TX_DATA;
    assign tx_pop  = DataInValid && DataInReady;
    assign rx_push = DataOutValid && DataOutReady;
    assign rx_pop  = rd && off == MMIO_RX_DATA;
    assign DataInValid  = !tx_empty;
    assign DataOutReady = !rx_full;
    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(din[7:0]),
        .dout(DataIn), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(DataOut),
        .dout(rx_byte), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );
    always_comb
        rdata = off == MMIO_TX_STAT ? {8'h0, drop, 8'(tx_count), 7'h0, !tx_full} :
                off == MMIO_RX_STAT ? {16'h0, 8'(rx_count), 7'h0, !rx_empty} :
                off == MMIO_RX_DATA ? {24'h0, rx_empty ? 8'h0 : rx_byte} :
                off == MMIO_CYC     ? 32'(cyc) :
                off == MMIO_INSTR   ? 32'(instr) : 32'h0;
    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= '0;
            drop  <= '0;
            cyc   <= '0;
            instr <= '0;
        end else begin
            if (rd) dout <= rdata;
            cyc   <= cnt_rst ? '0 : cyc + 1'b1;
            instr <= cnt_rst ? '0 : instr + CNT_W'(instr_retire && !stall);
            // a full push with no same-cycle pop is lost; count it until saturation
            if (cnt_rst) drop <= '0;
            else if (tx_push && tx_full && !tx_pop && drop != 8'hff) drop <= drop + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: directed scenario tests for uart_mmio_fifo with hand-computed expectations.
module tb_uart_mmio_fifo;
    logic clk = 0, rst = 1, stall = 0, re = 0, instr_retire = 0;
    logic [31:0] addr = 0, din = 0, dout;
    logic [3:0] we = 0;
    logic [7:0] DataIn, DataOut = 0;
    logic DataInValid, DataInReady = 0, DataOutValid = 0, DataOutReady;
    int vectors = 0, miscompares = 0;

    uart_mmio_fifo dut (
        .clk(clk), .rst(rst), .stall(stall), .addr(addr), .we(we), .re(re), .din(din),
        .dout(dout), .instr_retire(instr_retire), .DataIn(DataIn), .DataInValid(DataInValid),
        .DataInReady(DataInReady), .DataOut(DataOut), .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [7:0] off);
        addr = {4'h8, 20'h0, off};
        re = 1;
        tick();
        re = 0;
        addr = 0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        din = d;
        we = 4'hf;
        tick();
        we = 0;
        addr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        vectors++;
        if (dout !== 32'h0) begin miscompares++; $display("FAIL reset_dout got %h want 0", dout); end
        vectors++;
        if (DataInValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", DataInValid); end
        vectors++;
        if (DataOutReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", DataOutReady); end
        cpu_read(8'h00);
        vectors++;
        if (dout !== 32'h0000_0001) begin miscompares++; $display("FAIL reset_tx_stat got %h want 00000001", dout); end
        cpu_read(8'h04);
        vectors++;
        if (dout !== 32'h0000_0000) begin miscompares++; $display("FAIL reset_rx_stat got %h want 00000000", dout); end
    endtask

    task automatic test_tx_overflow();
        DataInReady = 0;
        for (int i = 0; i < 10; i++) cpu_write(32'h8000_0008, 32'h41 + i);
        cpu_write(32'h4000_0008, 32'h55);
        cpu_read(8'h00);
        vectors++;
        if (dout !== 32'h0002_0800) begin miscompares++; $display("FAIL tx_overflow_stat got %h want 00020800", dout); end
        DataInReady = 1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (DataInValid !== 1'b1 || DataIn !== 8'(8'h41 + i)) begin
                miscompares++;
                $display("FAIL tx_drain[%0d] got v=%b %h want v=1 %h", i, DataInValid, DataIn, 8'(8'h41 + i));
            end
            tick();
        end
        DataInReady = 0;
        vectors++;
        if (DataInValid !== 1'b0) begin miscompares++; $display("FAIL tx_drained_valid got %b want 0", DataInValid); end
    endtask

    task automatic test_rx_backpressure();
        DataOutValid = 1;
        for (int i = 0; i < 8; i++) begin
            DataOut = 8'(8'h10 + i);
            vectors++;
            if (DataOutReady !== 1'b1) begin miscompares++; $display("FAIL rx_fill_ready[%0d] got %b want 1", i, DataOutReady); end
            tick();
        end
        DataOut = 8'h18;
        vectors++;
        if (DataOutReady !== 1'b0) begin miscompares++; $display("FAIL rx_full_ready got %b want 0", DataOutReady); end
        cpu_read(8'h04);
        vectors++;
        if (dout !== 32'h0000_0801) begin miscompares++; $display("FAIL rx_full_stat got %h want 00000801", dout); end
        cpu_read(8'h0C);
        vectors++;
        if (dout !== 32'h10) begin miscompares++; $display("FAIL rx_first_byte got %h want 10", dout); end
        vectors++;
        if (DataOutReady !== 1'b1) begin miscompares++; $display("FAIL rx_ready_rise got %b want 1", DataOutReady); end
        tick();
        DataOutValid = 0;
        vectors++;
        if (DataOutReady !== 1'b0) begin miscompares++; $display("FAIL rx_ninth_accepted got %b want 0", DataOutReady); end
    endtask

    task automatic test_stall();
        addr = 32'h8000_000C;
        re = 1;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dout !== 32'h10) begin miscompares++; $display("FAIL stall_dout[%0d] got %h want 10", i, dout); end
        end
        stall = 0;
        tick();
        re = 0;
        addr = 0;
        vectors++;
        if (dout !== 32'h11) begin miscompares++; $display("FAIL stall_release got %h want 11", dout); end
        cpu_read(8'h04);
        vectors++;
        if (dout !== 32'h0000_0701) begin miscompares++; $display("FAIL stall_one_pop got %h want 00000701", dout); end
        for (int i = 0; i < 7; i++) begin
            cpu_read(8'h0C);
            vectors++;
            if (dout !== 32'(8'h12 + i)) begin miscompares++; $display("FAIL rx_drain[%0d] got %h want %h", i, dout, 32'(8'h12 + i)); end
        end
    endtask

    task automatic test_empty_rx();
        cpu_read(8'h04);
        vectors++;
        if (dout !== 32'h0) begin miscompares++; $display("FAIL empty_rx_stat got %h want 0", dout); end
        cpu_read(8'h10);
        cpu_read(8'h0C);
        vectors++;
        if (dout !== 32'h0) begin miscompares++; $display("FAIL empty_rx_read got %h want 0", dout); end
        cpu_read(8'h20);
        vectors++;
        if (dout !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got %h want 0", dout); end
    endtask

    task automatic test_counters();
        cpu_read(8'h00);
        vectors++;
        if (dout !== 32'h0002_0001) begin miscompares++; $display("FAIL drop_before_clear got %h want 00020001", dout); end
        cpu_write(32'h8000_0018, 32'h1);
        for (int i = 0; i < 20; i++) begin
            instr_retire = (i == 2 || i == 5 || i == 9 || i == 13 || i == 17);
            stall = (i == 9);
            tick();
        end
        instr_retire = 0;
        stall = 0;
        cpu_read(8'h14);
        vectors++;
        if (dout !== 32'd4) begin miscompares++; $display("FAIL instr_count got %0d want 4", dout); end
        cpu_read(8'h10);
        vectors++;
        if (dout !== 32'd21) begin miscompares++; $display("FAIL cycle_count got %0d want 21", dout); end
        cpu_read(8'h00);
        vectors++;
        if (dout !== 32'h0000_0001) begin miscompares++; $display("FAIL drop_cleared got %h want 00000001", dout); end
        instr_retire = 1;
        cpu_write(32'h8000_0018, 32'h0);
        instr_retire = 0;
        cpu_read(8'h10);
        vectors++;
        if (dout !== 32'h0) begin miscompares++; $display("FAIL cycle_after_clear got %h want 0", dout); end
        cpu_read(8'h14);
        vectors++;
        if (dout !== 32'h0) begin miscompares++; $display("FAIL instr_after_clear got %h want 0", dout); end
    endtask

    task automatic test_full_push_pop();
        DataInReady = 0;
        for (int i = 0; i < 8; i++) cpu_write(32'h8000_0008, 32'h60 + i);
        DataInReady = 1;
        vectors++;
        if (DataIn !== 8'h60) begin miscompares++; $display("FAIL full_head got %h want 60", DataIn); end
        cpu_write(32'h8000_0008, 32'h68);
        DataInReady = 0;
        cpu_read(8'h00);
        vectors++;
        if (dout !== 32'h0000_0800) begin miscompares++; $display("FAIL full_push_pop_stat got %h want 00000800", dout); end
        DataInReady = 1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (DataInValid !== 1'b1 || DataIn !== 8'(8'h61 + i)) begin
                miscompares++;
                $display("FAIL full_drain[%0d] got v=%b %h want v=1 %h", i, DataInValid, DataIn, 8'(8'h61 + i));
            end
            tick();
        end
        DataInReady = 0;
        vectors++;
        if (DataInValid !== 1'b0) begin miscompares++; $display("FAIL full_drained_valid got %b want 0", DataInValid); end
    endtask

    initial begin
        test_reset();
        test_tx_overflow();
        test_rx_backpressure();
        test_stall();
        test_empty_rx();
        test_counters();
        test_full_push_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
